core_tlb_search_arb: RTL and testbench
======================================

Name: core_tlb_search_arb

Overview:
Arbitrates the single TLB search port between the instruction-side and data-side address translation stages. The data side is the data fast-translation refill path. Each requester holds a level request with a virtual address. The block issues one search at a time to the TLB array, which has fixed 1-cycle read latency. It returns the tlb_s_resp_t to the granted requester with a one-cycle ready pulse. It sits between the translation front-ends and the TLB storage/compare block.

Parameters:
ASID_W, 10, ASID width carried to the TLB search.
DATA_FIRST, 1, tie-break owner after reset: 1 means D wins the first tie, 0 means I wins.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  translation change; aborts the in-flight search
asid_i  in  ASID_W  current CSR ASID
i_req_valid_i  in  1  instruction-side search request (level)
i_vaddr_i  in  32  instruction-side virtual address
i_req_ready_o  in/out  out  1  one-cycle pulse; i_resp_o is valid in this cycle
i_resp_o  out  tlb_s_resp_t  search result for the I side
d_req_valid_i  in  1  data-side search request (level)
d_vaddr_i  in  32  data-side virtual address
d_req_ready_o  out  1  one-cycle pulse; d_resp_o is valid in this cycle
d_resp_o  out  tlb_s_resp_t  search result for the D side
tlb_busy_i  in  1  TLB write/invalidate in progress; no search may issue
tlb_search_valid_o  out  1  search strobe to the TLB array
tlb_search_vppn_o  out  19  vaddr[31:13] of the granted request
tlb_search_odd_o  out  1  vaddr[12] of the granted request
tlb_search_asid_o  out  ASID_W  asid_i captured at issue
tlb_search_resp_i  in  tlb_s_resp_t  TLB result, valid exactly 1 cycle after tlb_search_valid_o

Behaviour:
- States: IDLE, RESP (plus RESP_Q with the optional feature). Reset: state=IDLE; both ready outputs 0; tlb_search_valid_o 0; last_grant_q = DATA_FIRST ? I : D; all registered search fields 0.
- IDLE, issue conditions: issue when (i_req_valid_i | d_req_valid_i) & !tlb_busy_i & !flush_i.
- IDLE, grant selection:
  - only one requester valid: it wins;
  - both valid: the side not equal to last_grant_q wins.
- IDLE, on issue:
  - register grant_q, vppn, odd and asid_i;
  - set last_grant_q = winner;
  - drive tlb_search_valid_o=1 in the following cycle;
  - go to RESP.
- Search-field timing: search fields are registered (the search strobe and fields appear 1 cycle after grant). The TLB response therefore arrives in the cycle after that; RESP spans both cycles, tracked with a 1-bit phase counter.
- RESP phase 0: tlb_search_valid_o=1, fields stable.
- RESP phase 1:
  - capture tlb_search_resp_i;
  - pulse ready on the granted side with resp = tlb_search_resp_i (combinational pass-through);
  - return to IDLE.
- Latency and throughput: request seen in IDLE at cycle N gives ready at N+2. Minimum spacing between grants is 3 cycles; back-to-back issue from the ready cycle is not allowed.
- Response outputs: i_resp_o/d_resp_o hold the last captured result when not ready; only the ready pulse qualifies them.
- The non-granted side's ready is 0 throughout.
- flush_i in any non-IDLE state:
  - go to IDLE next cycle;
  - no ready pulse;
  - tlb_search_valid_o deasserts next cycle;
  - last_grant_q keeps its updated value.
- flush_i and a new request in IDLE in the same cycle: no issue.
- tlb_busy_i only gates issue in IDLE; an issued search completes regardless.
- A requester dropping valid after grant is ignored; the ready pulse is still produced unless flush_i.
- Reset mid-search: immediate IDLE, outputs to reset values, no ready pulse.
- Assertions:
  - i_req_ready_o & d_req_ready_o never both 1;
  - ready only in RESP phase 1 (or RESP_Q).

Optional Feature:
Macro CORE_TLB_SEARCH_RESP_REG_EN.
- Defined: RESP phase 1 registers tlb_search_resp_i and moves to RESP_Q. RESP_Q pulses ready with the registered result and returns to IDLE. Latency becomes N+3; flush_i in RESP_Q suppresses the pulse.
- Undefined: RESP_Q does not exist; combinational pass-through as above.

Test Plan:
- Single D request: d_vaddr_i=0x1234_5000, asid_i=0x3, TLB returns found=1, ppn=0x8_0005 -> search vppn=0x091A2, odd=1, asid=0x3 at N+1; d_req_ready_o=1 at N+2 with ppn 0x8_0005; i_req_ready_o stays 0.
- Both valid continuously after reset (DATA_FIRST=1) -> grant order D, I, D, I; ready pulses 3 cycles apart (4 with the macro).
- tlb_busy_i=1 for 5 cycles with d_req_valid_i=1 -> no tlb_search_valid_o until the cycle after busy drops; then normal N+2 ready.
- flush_i asserted in RESP phase 1 -> no ready pulse; IDLE next cycle; a later held request is re-granted and completes.
- rst_n low during RESP phase 0 -> next cycle all outputs 0 and state IDLE; on release, the first tie is granted to D.
- Macro defined, single I request at N -> i_req_ready_o at N+3; value equals the TLB response sampled at N+2 even if tlb_search_resp_i changes at N+3.

Source files
------------

// File: rtl/core_tlb_search_arb.sv
// core_tlb_search_arb
// Shares the single TLB search port between the instruction-side and
// data-side translation stages. One search is in flight at a time. The TLB
// array answers exactly one cycle after the search strobe. The result is
// handed back to the granted side together with a one-cycle ready pulse.
// Ties between the two sides alternate, starting from DATA_FIRST.
// Optional build macro CORE_TLB_SEARCH_RESP_REG_EN registers the TLB result
// for one extra cycle (RESP_Q state) before it is returned.

package core_tlb_search_arb_pkg;

   typedef struct packed {
      logic        found;
      logic [19:0] ppn;
      logic [5:0]  ps;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_s_resp_t;

endpackage

module core_tlb_search_arb
   import core_tlb_search_arb_pkg::*;
#(
   parameter int ASID_W     = 10,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic [ASID_W-1:0] asid_i,
   input  logic              i_req_valid_i,
   input  logic [31:0]       i_vaddr_i,
   output logic              i_req_ready_o,
   output tlb_s_resp_t       i_resp_o,
   input  logic              d_req_valid_i,
   input  logic [31:0]       d_vaddr_i,
   output logic              d_req_ready_o,
   output tlb_s_resp_t       d_resp_o,
   input  logic              tlb_busy_i,
   output logic              tlb_search_valid_o,
   output logic [18:0]       tlb_search_vppn_o,
   output logic              tlb_search_odd_o,
   output logic [ASID_W-1:0] tlb_search_asid_o,
   input  tlb_s_resp_t       tlb_search_resp_i
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RESP   = 2'd1;
`ifdef CORE_TLB_SEARCH_RESP_REG_EN
   localparam logic [1:0] ST_RESP_Q = 2'd2;
`endif

   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   logic [1:0]        state_q;
   logic              phase_q;
   logic              grant_q;
   logic              last_grant_q;
   logic              search_valid_q;
   logic [18:0]       vppn_q;
   logic              odd_q;
   logic [ASID_W-1:0] asid_q;
   tlb_s_resp_t       i_resp_q;
   tlb_s_resp_t       d_resp_q;
`ifdef CORE_TLB_SEARCH_RESP_REG_EN
   tlb_s_resp_t       resp_hold_q;
`endif

   logic        issue;
   logic        winner;
   logic        pulse_phase;
   logic        pulse;
   tlb_s_resp_t pulse_resp;

   assign issue = (state_q == ST_IDLE) && (i_req_valid_i || d_req_valid_i)
                  && !tlb_busy_i && !flush_i;

   // Pick the winner: a lone requester wins, a tie goes to the side not served last
   always_comb begin
      winner = SIDE_I;
      if (i_req_valid_i && d_req_valid_i) begin
         winner = ~last_grant_q;
      end else if (d_req_valid_i) begin
         winner = SIDE_D;
      end
   end

`ifdef CORE_TLB_SEARCH_RESP_REG_EN
   assign pulse_phase = (state_q == ST_RESP_Q);
   assign pulse_resp  = resp_hold_q;
`else
   assign pulse_phase = (state_q == ST_RESP) && phase_q;
   assign pulse_resp  = tlb_search_resp_i;
`endif

   // A flush or a reset in the delivery cycle kills the pulse outright
   assign pulse = pulse_phase && !flush_i && rst_n;

   assign i_req_ready_o      = pulse && (grant_q == SIDE_I);
   assign d_req_ready_o      = pulse && (grant_q == SIDE_D);
   assign i_resp_o           = i_req_ready_o ? pulse_resp : i_resp_q;
   assign d_resp_o           = d_req_ready_o ? pulse_resp : d_resp_q;
   assign tlb_search_valid_o = search_valid_q;
   assign tlb_search_vppn_o  = vppn_q;
   assign tlb_search_odd_o   = odd_q;
   assign tlb_search_asid_o  = asid_q;

   // Sequence one search: issue from IDLE, strobe, collect the answer, return
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         phase_q        <= 1'b0;
         grant_q        <= SIDE_I;
         last_grant_q   <= DATA_FIRST ? SIDE_I : SIDE_D;
         search_valid_q <= 1'b0;
         vppn_q         <= '0;
         odd_q          <= 1'b0;
         asid_q         <= '0;
         i_resp_q       <= '0;
         d_resp_q       <= '0;
`ifdef CORE_TLB_SEARCH_RESP_REG_EN
         resp_hold_q    <= '0;
`endif
      end else begin
         search_valid_q <= issue;
         if (pulse) begin
            if (grant_q == SIDE_D) begin
               d_resp_q <= pulse_resp;
            end else begin
               i_resp_q <= pulse_resp;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  grant_q      <= winner;
                  last_grant_q <= winner;
                  vppn_q       <= winner ? d_vaddr_i[31:13] : i_vaddr_i[31:13];
                  odd_q        <= winner ? d_vaddr_i[12] : i_vaddr_i[12];
                  asid_q       <= asid_i;
                  phase_q      <= 1'b0;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (flush_i) begin
                  phase_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (!phase_q) begin
                  phase_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
`ifdef CORE_TLB_SEARCH_RESP_REG_EN
                  resp_hold_q <= tlb_search_resp_i;
                  state_q     <= ST_RESP_Q;
`else
                  state_q     <= ST_IDLE;
`endif
               end
            end
`ifdef CORE_TLB_SEARCH_RESP_REG_EN
            ST_RESP_Q: begin
               state_q <= ST_IDLE;
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Only one side may ever see a ready pulse at a time
   assert property (@(posedge clk) disable iff (!rst_n)
      !(i_req_ready_o && d_req_ready_o));

   // Ready pulses occur only in the delivery cycle of a search
   assert property (@(posedge clk) disable iff (!rst_n)
      (i_req_ready_o || d_req_ready_o) |-> pulse_phase);

endmodule

// File: tb/tb_core_tlb_search_arb.sv
// tb_core_tlb_search_arb
// Directed bench for core_tlb_search_arb. A small TLB responder answers each
// search one cycle after the strobe with ppn = {odd, vppn} and found = 1.
// Outside that answer cycle it drives a junk result (found = 0, ppn = all ones).
// Honours CORE_TLB_SEARCH_RESP_REG_EN for the expected response latency.

module tb_core_tlb_search_arb;
   import core_tlb_search_arb_pkg::*;

`ifdef CORE_TLB_SEARCH_RESP_REG_EN
   localparam int RESP_LAT = 3;
`else
   localparam int RESP_LAT = 2;
`endif
   localparam int SPACING = RESP_LAT + 1;

   logic        clk;
   logic        rst_n;
   logic        flush_i;
   logic [9:0]  asid_i;
   logic        i_req_valid_i;
   logic [31:0] i_vaddr_i;
   logic        i_req_ready_o;
   tlb_s_resp_t i_resp_o;
   logic        d_req_valid_i;
   logic [31:0] d_vaddr_i;
   logic        d_req_ready_o;
   tlb_s_resp_t d_resp_o;
   logic        tlb_busy_i;
   logic        tlb_search_valid_o;
   logic [18:0] tlb_search_vppn_o;
   logic        tlb_search_odd_o;
   logic [9:0]  tlb_search_asid_o;
   tlb_s_resp_t tlb_search_resp_i;

   int total;
   int passed;

   logic        validSeen;
   logic [18:0] vppnSeen;
   logic        oddSeen;

   core_tlb_search_arb #(.ASID_W(10), .DATA_FIRST(1'b1)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_i            (flush_i),
      .asid_i             (asid_i),
      .i_req_valid_i      (i_req_valid_i),
      .i_vaddr_i          (i_vaddr_i),
      .i_req_ready_o      (i_req_ready_o),
      .i_resp_o           (i_resp_o),
      .d_req_valid_i      (d_req_valid_i),
      .d_vaddr_i          (d_vaddr_i),
      .d_req_ready_o      (d_req_ready_o),
      .d_resp_o           (d_resp_o),
      .tlb_busy_i         (tlb_busy_i),
      .tlb_search_valid_o (tlb_search_valid_o),
      .tlb_search_vppn_o  (tlb_search_vppn_o),
      .tlb_search_odd_o   (tlb_search_odd_o),
      .tlb_search_asid_o  (tlb_search_asid_o),
      .tlb_search_resp_i  (tlb_search_resp_i)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Remember what the TLB was asked during the cycle that just ended
   always @(negedge clk) begin
      validSeen = tlb_search_valid_o;
      vppnSeen  = tlb_search_vppn_o;
      oddSeen   = tlb_search_odd_o;
   end

   // TLB array model: answer exactly one cycle after the strobe, junk otherwise
   always begin
      @(posedge clk);
      #1;
      tlb_search_resp_i = '0;
      if (validSeen) begin
         tlb_search_resp_i.found = 1'b1;
         tlb_search_resp_i.ppn   = {oddSeen, vppnSeen};
      end else begin
         tlb_search_resp_i.ppn   = 20'hFFFFF;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                input logic dv, input logic [31:0] da,
                                input logic busy, input logic fl);
      i_req_valid_i = iv;
      i_vaddr_i     = ia;
      d_req_valid_i = dv;
      d_vaddr_i     = da;
      tlb_busy_i    = busy;
      flush_i       = fl;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut;
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) tick;
      rst_n = 1'b1;
   endtask

   // Follow one search from the current (issue) cycle to its ready pulse
   task automatic waitReady(input logic side, input logic [19:0] expPpn, input string tag);
      int lat;
      int vcyc;
      logic other;
      logic [19:0] gotPpn;
      lat    = -1;
      vcyc   = -1;
      other  = 1'b0;
      gotPpn = 20'hFFFFF;
      for (int c = 0; c < 10 && lat < 0; c++) begin
         @(negedge clk);
         if (tlb_search_valid_o && vcyc < 0) vcyc = c;
         if (side ? i_req_ready_o : d_req_ready_o) other = 1'b1;
         if (side ? d_req_ready_o : i_req_ready_o) begin
            lat    = c;
            gotPpn = side ? d_resp_o.ppn : i_resp_o.ppn;
         end
      end
      checkOutput({tag, " strobe cycle"}, vcyc, 1);
      checkOutput({tag, " ready latency"}, lat, RESP_LAT);
      checkOutput({tag, " ppn"}, {12'h0, gotPpn}, {12'h0, expPpn});
      checkOutput({tag, " other side ready"}, {31'h0, other}, 0);
   endtask

   initial begin
      int nPulse;
      logic expSide;
      total  = 0;
      passed = 0;
      asid_i = 10'h0;
      tlb_search_resp_i = '0;
      validSeen = 1'b0;
      vppnSeen  = '0;
      oddSeen   = 1'b0;

      // Reset values
      resetDut;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset i_ready", {31'h0, i_req_ready_o}, 0);
      checkOutput("reset d_ready", {31'h0, d_req_ready_o}, 0);
      checkOutput("reset strobe", {31'h0, tlb_search_valid_o}, 0);
      checkOutput("reset vppn", {13'h0, tlb_search_vppn_o}, 0);
      checkOutput("reset asid", {22'h0, tlb_search_asid_o}, 0);
      tick;
      rst_n = 1'b1;

      // Single D request; valid and ASID drop right after the grant
      tick;
      asid_i = 10'h3;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h1234_5000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1 strobe at grant", {31'h0, tlb_search_valid_o}, 0);
      tick;
      asid_i = 10'h0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1 strobe", {31'h0, tlb_search_valid_o}, 1);
      checkOutput("t1 vppn", {13'h0, tlb_search_vppn_o}, 32'h091A2);
      checkOutput("t1 odd", {31'h0, tlb_search_odd_o}, 1);
      checkOutput("t1 asid", {22'h0, tlb_search_asid_o}, 3);
      checkOutput("t1 d_ready phase0", {31'h0, d_req_ready_o}, 0);
      for (int k = 2; k < RESP_LAT; k++) begin
         tick;
         @(negedge clk);
         checkOutput("t1 early ready", {31'h0, d_req_ready_o}, 0);
      end
      tick;
      @(negedge clk);
      checkOutput("t1 d_ready", {31'h0, d_req_ready_o}, 1);
      checkOutput("t1 i_ready", {31'h0, i_req_ready_o}, 0);
      checkOutput("t1 ppn", {12'h0, d_resp_o.ppn}, 32'h891A2);
      checkOutput("t1 found", {31'h0, d_resp_o.found}, 1);
      tick;
      @(negedge clk);
      checkOutput("t1 d_ready after", {31'h0, d_req_ready_o}, 0);
      checkOutput("t1 held ppn", {12'h0, d_resp_o.ppn}, 32'h891A2);
      checkOutput("t1 strobe after", {31'h0, tlb_search_valid_o}, 0);

      // Both sides held after reset: D, I, D, I
      resetDut;
      applyStimulus(1'b1, 32'h0000_2000, 1'b1, 32'h0000_7000, 1'b0, 1'b0);
      nPulse = 0;
      for (int c = 0; c < 40 && nPulse < 4; c++) begin
         @(negedge clk);
         if (i_req_ready_o || d_req_ready_o) begin
            expSide = (nPulse % 2 == 0);
            checkOutput("alt side", {31'h0, d_req_ready_o}, {31'h0, expSide});
            checkOutput("alt cycle", c, RESP_LAT + nPulse * SPACING);
            checkOutput("alt ppn", {12'h0, d_req_ready_o ? d_resp_o.ppn : i_resp_o.ppn},
                        expSide ? 32'h80003 : 32'h00001);
            nPulse++;
         end
      end
      checkOutput("alt pulse count", nPulse, 4);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // TLB busy holds off issue for 5 cycles
      tick;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("busy no strobe", {31'h0, tlb_search_valid_o}, 0);
         tick;
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b0, 1'b0);
      waitReady(1'b1, 20'h00002, "busy");
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Flush in RESP phase 1, then the held request is served again
      tick;
      applyStimulus(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      tick;
      @(negedge clk);
      checkOutput("flush strobe", {31'h0, tlb_search_valid_o}, 1);
      tick;
      applyStimulus(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush i_ready", {31'h0, i_req_ready_o}, 0);
      checkOutput("flush d_ready", {31'h0, d_req_ready_o}, 0);
      tick;
      applyStimulus(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 1'b0);
      waitReady(1'b0, 20'h00001, "after flush");
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Flush with a request in IDLE blocks the issue
      tick;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b0, 1'b1);
      @(negedge clk);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("idle flush no strobe", {31'h0, tlb_search_valid_o}, 0);

      // Reset during RESP phase 0, then the first tie goes to D
      tick;
      applyStimulus(1'b1, 32'h0000_2000, 1'b1, 32'h0000_7000, 1'b0, 1'b0);
      @(negedge clk);
      tick;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst strobe before", {31'h0, tlb_search_valid_o}, 1);
      tick;
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst i_ready", {31'h0, i_req_ready_o}, 0);
      checkOutput("rst d_ready", {31'h0, d_req_ready_o}, 0);
      checkOutput("rst strobe", {31'h0, tlb_search_valid_o}, 0);
      checkOutput("rst vppn", {13'h0, tlb_search_vppn_o}, 0);
      tick;
      applyStimulus(1'b1, 32'h0000_2000, 1'b1, 32'h0000_7000, 1'b0, 1'b0);
      waitReady(1'b1, 20'h80003, "tie after reset");
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      tick;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
